priority_grant_sequencer: RTL and testbench

Consumer side of the 12-request priority encoding scheme. The block captures a 12-bit request vector on start. It then issues grants one at a time, highest index first, as both an encoded index and a decoded one-hot vector, under a valid/ack handshake. Unanswered grants are dropped after a timeout. Sits between request sources and the downstream servicing unit that acknowledges each grant.

---
 rtl/priority_grant_sequencer_if.sv | 23 ++
 rtl/priority_grant_sequencer.sv | 103 ++++++++++
 tb/tb_priority_grant_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_grant_sequencer_if.sv
// rtl/priority_grant_sequencer_if.sv - request/grant handshake bundle for priority_grant_sequencer
interface priority_grant_sequencer_if;
  logic        start;
  logic [11:0] req;
  logic        ack;
  logic        busy;
  logic        gnt_valid;
  logic [11:0] gnt;
  logic [3:0]  gnt_idx;
  logic        done_tick;
  logic [3:0]  serviced_cnt;
  logic [11:0] dropped;

  modport master (
    output start, req, ack,
    input  busy, gnt_valid, gnt, gnt_idx, done_tick, serviced_cnt, dropped
  );

  modport slave (
    input  start, req, ack,
    output busy, gnt_valid, gnt, gnt_idx, done_tick, serviced_cnt, dropped
  );
endinterface

// File: rtl/priority_grant_sequencer.sv
// rtl/priority_grant_sequencer.sv - snapshots a 12-bit request vector and grants it highest bit first
module priority_grant_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                        clk,
  input logic                        reset,
  priority_grant_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [11:0] pend;
  logic [3:0]  timer;
  logic [3:0]  serviced_cnt;
  logic [11:0] dropped;

  logic [11:0] top_onehot;
  logic [3:0]  top_idx;
  logic [11:0] pend_next;
  logic        serving;

  // Ascending scan: the last set bit seen is the highest one, so it wins.
  always_comb begin
    top_onehot = '0;
    top_idx    = '0;
    for (int i = 0; i < 12; i++) begin
      if (pend[i]) begin
        top_onehot    = '0;
        top_onehot[i] = 1'b1;
        top_idx       = 4'(i + 1);
      end
    end
  end

  assign pend_next = pend & ~top_onehot;
  assign serving   = (state == ST_SERVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pend         <= '0;
      timer        <= '0;
      serviced_cnt <= '0;
      dropped      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pend         <= bus.req;
            serviced_cnt <= '0;
            dropped      <= '0;
            timer        <= '0;
            state        <= (bus.req == 12'd0) ? ST_DONE : ST_SERVE;
          end
        end

        ST_SERVE: begin
          // ack beats a coinciding timeout: the bit counts as serviced.
          if (bus.ack) begin
            pend         <= pend_next;
            serviced_cnt <= serviced_cnt + 4'd1;
            timer        <= '0;
            if (pend_next == 12'd0) begin
              state <= ST_DONE;
            end
          end else if (timer == TIMER_LAST) begin
            pend    <= pend_next;
            dropped <= dropped | top_onehot;
            timer   <= '0;
            if (pend_next == 12'd0) begin
              state <= ST_DONE;
            end
          end else begin
            timer <= timer + 4'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant outputs depend only on registered state, so reset clears them at once.
  assign bus.gnt_valid    = serving;
  assign bus.gnt          = serving ? top_onehot : 12'd0;
  assign bus.gnt_idx      = serving ? top_idx : 4'd0;
  assign bus.busy         = (state == ST_SERVE) || (state == ST_DONE);
  assign bus.done_tick    = (state == ST_DONE);
  assign bus.serviced_cnt = serviced_cnt;
  assign bus.dropped      = dropped;

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// tb/tb_priority_grant_sequencer.sv - scoreboard bench for priority_grant_sequencer
module tb_priority_grant_sequencer;
  localparam int T = 4;

  logic clk;
  logic reset;
  bit   mon_en;
  int   n_checks;
  int   n_fails;

  int   exp_idx_q[$];
  int   exp_svc_q[$];
  int   exp_drop_q[$];
  int   dly[12];

  priority_grant_sequencer_if dut_if ();

  priority_grant_sequencer #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a grant must match the model's next expected grant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dut_if.gnt_valid) begin
        if (exp_idx_q.size() == 0) begin
          chk(1'b0, "unexpected_grant", int'(dut_if.gnt_idx), 0);
        end else begin
          int e;
          logic [11:0] eg;
          e  = exp_idx_q.pop_front();
          eg = 12'd1 << (e - 1);
          chk(dut_if.gnt_idx == 4'(e), "gnt_idx", int'(dut_if.gnt_idx), e);
          chk(dut_if.gnt == eg, "gnt_onehot", int'(dut_if.gnt), int'(eg));
          chk(dut_if.busy == 1'b1, "busy_in_serve", int'(dut_if.busy), 1);
        end
      end else begin
        chk(dut_if.gnt == 12'd0 && dut_if.gnt_idx == 4'd0, "gnt_idle_zero",
            int'({dut_if.gnt, dut_if.gnt_idx}), 0);
      end
      if (dut_if.done_tick) begin
        if (exp_svc_q.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          int es;
          int ed;
          es = exp_svc_q.pop_front();
          ed = exp_drop_q.pop_front();
          chk(dut_if.serviced_cnt == 4'(es), "serviced_cnt", int'(dut_if.serviced_cnt), es);
          chk(dut_if.dropped == 12'(ed), "dropped", int'(dut_if.dropped), ed);
          chk(exp_idx_q.size() == 0, "grants_left_at_done", exp_idx_q.size(), 0);
        end
      end
    end
  end

  // Model: walk the snapshot highest bit first; each grant lasts until its ack
  // (delay+1 cycles) or T cycles when the delay reaches the timeout.
  task automatic run_seq(input logic [11:0] r, input bit noise);
    int          cyc_q[$];
    int          ack_at[$];
    int          svc;
    logic [11:0] drp;
    svc = 0;
    drp = '0;
    for (int i = 11; i >= 0; i--) begin
      if (r[i]) begin
        if (dly[i] < T) begin
          for (int n = 0; n <= dly[i]; n++) exp_idx_q.push_back(i + 1);
          cyc_q.push_back(dly[i] + 1);
          ack_at.push_back(dly[i]);
          svc++;
        end else begin
          for (int n = 0; n < T; n++) exp_idx_q.push_back(i + 1);
          cyc_q.push_back(T);
          ack_at.push_back(-1);
          drp[i] = 1'b1;
        end
      end
    end
    exp_svc_q.push_back(svc);
    exp_drop_q.push_back(int'(drp));

    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.req   = r;
    dut_if.ack   = 1'b0;
    @(posedge clk);
    for (int k = 0; k < cyc_q.size(); k++) begin
      for (int c = 0; c < cyc_q[k]; c++) begin
        @(negedge clk);
        dut_if.ack = (c == ack_at[k]);
        if (noise) begin
          dut_if.start = 1'($urandom);
          dut_if.req   = 12'($urandom);
        end else begin
          dut_if.start = 1'b0;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    dut_if.ack   = noise ? 1'($urandom) : 1'b0;
    dut_if.start = noise;
    chk(dut_if.done_tick == 1'b1, "done_tick_timing", int'(dut_if.done_tick), 1);
    chk(dut_if.busy == 1'b1, "busy_in_done", int'(dut_if.busy), 1);
    @(posedge clk);
    #1;
    chk(dut_if.busy == 1'b0, "busy_after_done", int'(dut_if.busy), 0);
    chk(dut_if.done_tick == 1'b0, "done_tick_one_cycle", int'(dut_if.done_tick), 0);
    dut_if.start = 1'b0;
    dut_if.ack   = 1'b0;
  endtask

  task automatic set_dly(input int v);
    for (int i = 0; i < 12; i++) dly[i] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    mon_en       = 1'b0;
    reset        = 1'b1;
    dut_if.start = 1'b0;
    dut_if.req   = '0;
    dut_if.ack   = 1'b0;
    #1;
    chk(dut_if.gnt_valid == 1'b0, "reset_gnt_valid", int'(dut_if.gnt_valid), 0);
    chk(dut_if.busy == 1'b0, "reset_busy", int'(dut_if.busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-serve must kill the grant without a clock edge.
    dut_if.start = 1'b1;
    dut_if.req   = 12'hFFF;
    @(posedge clk);
    @(negedge clk);
    dut_if.start = 1'b0;
    @(negedge clk);
    chk(dut_if.gnt_valid == 1'b1, "serve_before_reset", int'(dut_if.gnt_valid), 1);
    chk(dut_if.gnt_idx == 4'd12, "serve_idx_before_reset", int'(dut_if.gnt_idx), 12);
    reset = 1'b1;
    #1;
    chk(dut_if.gnt_valid == 1'b0, "async_gnt_valid", int'(dut_if.gnt_valid), 0);
    chk(dut_if.gnt == 12'd0, "async_gnt", int'(dut_if.gnt), 0);
    chk(dut_if.gnt_idx == 4'd0, "async_gnt_idx", int'(dut_if.gnt_idx), 0);
    chk(dut_if.done_tick == 1'b0, "async_done_tick", int'(dut_if.done_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk(dut_if.busy == 1'b0, "post_reset_busy", int'(dut_if.busy), 0);
    chk(dut_if.serviced_cnt == 4'd0, "post_reset_serviced", int'(dut_if.serviced_cnt), 0);
    chk(dut_if.dropped == 12'd0, "post_reset_dropped", int'(dut_if.dropped), 0);
    mon_en = 1'b1;

    set_dly(0);
    run_seq(12'h805, 1'b0);
    run_seq(12'h000, 1'b0);
    set_dly(T);
    run_seq(12'h030, 1'b0);
    set_dly(T - 1);
    run_seq(12'h001, 1'b0);
    set_dly(2);
    run_seq(12'h100, 1'b1);
    set_dly(0);
    run_seq(12'hFFF, 1'b0);

    for (int s = 0; s < 40; s++) begin
      logic [11:0] r;
      for (int i = 0; i < 12; i++) dly[i] = int'($urandom_range(0, T + 1));
      r = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
      run_seq(r, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk(exp_idx_q.size() == 0, "grant_queue_empty", exp_idx_q.size(), 0);
    chk(exp_svc_q.size() == 0, "summary_queue_empty", exp_svc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
